store_write_unit: RTL and testbench
===================================

STORE_WRITE_UNIT -- requirements
Module: store_write_unit

Interface
REQ-001 Parameter: ADDR_W, 32, width of addr and mem_addr.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle store request strobe from the controller's memory-write state.
REQ-005 funct3  input  3  store type: 000 sb, 001 sh, 010 sw.
REQ-006 addr  input  ADDR_W  byte address of the store.
REQ-007 wdata_in  input  32  store source (rs2), LSB-aligned.
REQ-008 mem_rdata  input  32  data-memory read word, valid one cycle after mem_re.
REQ-009 mem_addr  output  ADDR_W  word-aligned address (addr[1:0] forced to 00).
REQ-010 mem_wdata  output  32  word presented to memory.
REQ-011 mem_we  output  1  one-cycle write strobe.
REQ-012 mem_re  output  1  one-cycle read strobe (read-modify-write path only).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 misaligned  output  1  error flag for the most recent request.

Function
REQ-016 States: IDLE, READ, MERGE, WRITE, DONE; one-hot or binary at implementer's choice.
REQ-017 In IDLE, start=1 latches funct3, addr, wdata_in and clears misaligned.
REQ-018 start while busy=1 is ignored; no latch, no state change.
REQ-019 Misaligned: sh with addr[0]=1, sw with addr[1:0]!=00, or funct3 not in {000,001,010}; such a request goes IDLE->DONE, sets misaligned=1, never asserts mem_we or mem_re.
REQ-020 Aligned sw: IDLE->WRITE->DONE->IDLE; mem_we=1 in cycle N+1 after start in N, done=1 in N+2.
REQ-021 sb/sh (no macro): IDLE->READ (mem_re=1)->MERGE (capture mem_rdata)->WRITE (mem_we=1)->DONE; mem_re at N+1, mem_we at N+3, done at N+4.
REQ-022 Merge: sb replaces byte lane addr[1:0] with wdata_in[7:0]; sh replaces half-word lane addr[1] with wdata_in[15:0]; remaining lanes from captured mem_rdata unchanged.
REQ-023 mem_addr holds the latched word address from the cycle after start until return to IDLE; 0 in IDLE.
REQ-024 mem_wdata is valid only while mem_we=1; 0 otherwise.
REQ-025 mem_we and mem_re are never high in the same cycle and each is high for exactly one cycle per request.
REQ-026 done is high only in DONE; DONE always returns to IDLE next cycle; start in the DONE cycle is ignored.
REQ-027 misaligned holds its value until the next accepted start.

Reset
REQ-028 rst=1 at a clock edge forces IDLE regardless of state, including mid-READ/MERGE/WRITE; the aborted store is discarded.
REQ-029 Reset values: mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, done=0, misaligned=0, latched operands=0.

Configuration
REQ-030 Macro STORE_BYTE_MASK_EN: when defined, adds output mem_be (4 bits, byte write enables, 0 outside WRITE); sb/sh take IDLE->WRITE->DONE like sw, mem_re is never asserted, mem_wdata replicates the byte (sb) or half-word (sh) into all lanes, mem_be selects the lane(s) (sw: 1111).
REQ-031 Without STORE_BYTE_MASK_EN: no mem_be port; sub-word stores use the read-modify-write path of REQ-021.

Verification
REQ-032 sw addr=0x100, wdata_in=0xDEADBEEF -> N+1 mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; N+2 done=1, misaligned=0.
REQ-033 sb addr=0x103, wdata_in=0x000000AB, mem_rdata=0x11223344 (no macro) -> mem_re at N+1, mem_we at N+3 with mem_wdata=0xAB223344, done at N+4.
REQ-034 sh addr=0x201 -> done at N+1, misaligned=1, no mem_we/mem_re in any cycle.
REQ-035 sb in progress, rst=1 in MERGE cycle -> next cycle IDLE, busy=0, mem_we never asserted; new sw then completes per REQ-032.
REQ-036 start pulses at N and N+1 (sw) -> one write only; second start ignored.
REQ-037 With STORE_BYTE_MASK_EN, sh addr=0x302, wdata_in=0x0000BEEF -> N+1 mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_re never high.

Source files
------------

// File: rtl/store_write_unit_if.sv
// Request/memory/status bundle for store_write_unit; slave = the unit, master = controller + memory.
// mem_be exists only when STORE_BYTE_MASK_EN is defined.
interface store_write_unit_if #(parameter int ADDR_W = 32);
    logic              start;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata_in;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              busy;
    logic              done;
    logic              misaligned;
`ifdef STORE_BYTE_MASK_EN
    logic [3:0]        mem_be;
`endif

    modport slave (
        input  start, funct3, addr, wdata_in, mem_rdata,
`ifdef STORE_BYTE_MASK_EN
        output mem_be,
`endif
        output mem_addr, mem_wdata, mem_we, mem_re, busy, done, misaligned
    );

    modport master (
        output start, funct3, addr, wdata_in, mem_rdata,
`ifdef STORE_BYTE_MASK_EN
        input  mem_be,
`endif
        input  mem_addr, mem_wdata, mem_we, mem_re, busy, done, misaligned
    );
endinterface

// File: rtl/store_write_unit.sv
// Store write unit: sb/sh/sw to a word-wide data memory, read-modify-write for sub-word stores.
// STORE_BYTE_MASK_EN: sub-word stores use byte enables (mem_be) instead of read-modify-write.
module store_write_unit #(
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    store_write_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

    state_t            state, next;
    logic [ADDR_W-3:0] waddr_q;
    logic [1:0]        lane_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              mis_q;
    logic              req_mis;
    logic [31:0]       wr_word;
`ifdef STORE_BYTE_MASK_EN
    logic [3:0]        be;
`else
    logic [31:0]       rdata_q;
`endif

    always_comb begin
        req_mis = 1'b0;
        case (bus.funct3)
            3'b000:  req_mis = 1'b0;
            3'b001:  req_mis = bus.addr[0];
            3'b010:  req_mis = |bus.addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            waddr_q  <= '0;
            lane_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            mis_q    <= 1'b0;
`ifndef STORE_BYTE_MASK_EN
            rdata_q  <= '0;
`endif
        end else begin
            state <= next;
            if (state == IDLE && bus.start) begin
                waddr_q  <= bus.addr[ADDR_W-1:2];
                lane_q   <= bus.addr[1:0];
                funct3_q <= bus.funct3;
                wdata_q  <= bus.wdata_in;
                mis_q    <= req_mis;
            end
`ifndef STORE_BYTE_MASK_EN
            if (state == MERGE)
                rdata_q <= bus.mem_rdata;
`endif
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (req_mis)
                        next = DONE;
                    else if (bus.funct3 == 3'b010)
                        next = WRITE;
                    else
`ifdef STORE_BYTE_MASK_EN
                        next = WRITE;
`else
                        next = READ;
`endif
                end
            end
            READ:    next = MERGE;
            MERGE:   next = WRITE;
            WRITE:   next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Word actually written: merged with the captured read word, or lane-replicated with enables.
    always_comb begin
`ifdef STORE_BYTE_MASK_EN
        wr_word = wdata_q;
        be      = 4'b0000;
        case (funct3_q)
            3'b000: begin
                wr_word = {4{wdata_q[7:0]}};
                be      = 4'b0001 << lane_q;
            end
            3'b001: begin
                wr_word = {2{wdata_q[15:0]}};
                be      = lane_q[1] ? 4'b1100 : 4'b0011;
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
`else
        wr_word = rdata_q;
        case (funct3_q)
            3'b000:  wr_word[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            3'b001:  wr_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
`endif
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.mem_re     = (state == READ);
        bus.mem_we     = (state == WRITE);
        bus.mem_addr   = (state != IDLE) ? {waddr_q, 2'b00} : '0;
        bus.mem_wdata  = (state == WRITE) ? wr_word : '0;
        bus.misaligned = mis_q;
`ifdef STORE_BYTE_MASK_EN
        bus.mem_be     = (state == WRITE) ? be : 4'b0000;
`endif
    end
endmodule

// File: tb/tb_store_write_unit.sv
// Directed self-checking bench for store_write_unit (default build and STORE_BYTE_MASK_EN build).
module tb_store_write_unit;
    logic clk = 1'b0;
    logic rst;

    store_write_unit_if #(.ADDR_W(32)) bus ();

    store_write_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned we_cnt = 0;
    int unsigned re_cnt = 0;
    int unsigned overlap = 0;
    logic        re_seen = 1'b0;
    logic [31:0] rd_word = 32'h0;

    // Strobe counters sampled mid-cycle, memory returns rd_word the cycle after mem_re.
    always @(negedge clk) begin
        if (bus.mem_we) we_cnt++;
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we && bus.mem_re) overlap++;
        re_seen = bus.mem_re;
    end

    always @(posedge clk) bus.mem_rdata <= re_seen ? rd_word : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start in the current cycle N and returns in cycle N+1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata_in = wd;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic sw_store(input logic [31:0] a, input logic [31:0] wd);
        int unsigned w0;
        w0 = we_cnt;
        issue(3'b010, a, wd);
        check_eq("sw_we",    32'(bus.mem_we), 32'd1);
        check_eq("sw_re",    32'(bus.mem_re), 32'd0);
        check_eq("sw_addr",  bus.mem_addr, {a[31:2], 2'b00});
        check_eq("sw_wdata", bus.mem_wdata, wd);
`ifdef STORE_BYTE_MASK_EN
        check_eq("sw_be",    32'(bus.mem_be), 32'hF);
`endif
        tick();
        check_eq("sw_done",  32'(bus.done), 32'd1);
        check_eq("sw_mis",   32'(bus.misaligned), 32'd0);
        check_eq("sw_wd0",   bus.mem_wdata, 32'h0);
        tick();
        check_eq("sw_idle",  32'(bus.busy), 32'd0);
        check_eq("sw_addr0", bus.mem_addr, 32'h0);
        check_eq("sw_nwe",   we_cnt - w0, 32'd1);
    endtask

`ifdef STORE_BYTE_MASK_EN
    task automatic sub_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_word,
                             input logic [3:0] exp_be);
        int unsigned w0, r0;
        w0 = we_cnt;
        r0 = re_cnt;
        issue(f3, a, wd);
        check_eq({tag, "_we"},    32'(bus.mem_we), 32'd1);
        check_eq({tag, "_wdata"}, bus.mem_wdata, exp_word);
        check_eq({tag, "_be"},    32'(bus.mem_be), 32'(exp_be));
        tick();
        check_eq({tag, "_done"},  32'(bus.done), 32'd1);
        check_eq({tag, "_be0"},   32'(bus.mem_be), 32'd0);
        tick();
        check_eq({tag, "_nre"},   re_cnt - r0, 32'd0);
        check_eq({tag, "_nwe"},   we_cnt - w0, 32'd1);
    endtask
`else
    task automatic sub_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input logic [31:0] exp_word);
        int unsigned w0, r0;
        w0 = we_cnt;
        r0 = re_cnt;
        rd_word = rd;
        issue(f3, a, wd);
        check_eq({tag, "_re"},    32'(bus.mem_re), 32'd1);
        check_eq({tag, "_we1"},   32'(bus.mem_we), 32'd0);
        check_eq({tag, "_addr"},  bus.mem_addr, {a[31:2], 2'b00});
        tick();
        check_eq({tag, "_merge"}, 32'(bus.mem_re | bus.mem_we), 32'd0);
        tick();
        check_eq({tag, "_we"},    32'(bus.mem_we), 32'd1);
        check_eq({tag, "_wdata"}, bus.mem_wdata, exp_word);
        tick();
        check_eq({tag, "_done"},  32'(bus.done), 32'd1);
        tick();
        check_eq({tag, "_idle"},  32'(bus.busy), 32'd0);
        check_eq({tag, "_nre"},   re_cnt - r0, 32'd1);
        check_eq({tag, "_nwe"},   we_cnt - w0, 32'd1);
    endtask
`endif

    task automatic mis_store(input string tag, input logic [2:0] f3, input logic [31:0] a);
        int unsigned w0, r0;
        w0 = we_cnt;
        r0 = re_cnt;
        issue(f3, a, 32'h5A5A5A5A);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
        check_eq({tag, "_mis"},  32'(bus.misaligned), 32'd1);
        tick();
        check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_hold"}, 32'(bus.misaligned), 32'd1);
        check_eq({tag, "_nwe"},  we_cnt - w0, 32'd0);
        check_eq({tag, "_nre"},  re_cnt - r0, 32'd0);
    endtask

    initial begin
        int unsigned w0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = 3'b000;
        bus.addr     = 32'h0;
        bus.wdata_in = 32'h0;
        tick();
        tick();
        check_eq("rst_busy",  32'(bus.busy), 32'd0);
        check_eq("rst_done",  32'(bus.done), 32'd0);
        check_eq("rst_we",    32'(bus.mem_we), 32'd0);
        check_eq("rst_re",    32'(bus.mem_re), 32'd0);
        check_eq("rst_addr",  bus.mem_addr, 32'h0);
        check_eq("rst_wdata", bus.mem_wdata, 32'h0);
        check_eq("rst_mis",   32'(bus.misaligned), 32'd0);
        rst = 1'b0;
        tick();

        sw_store(32'h100, 32'hDEADBEEF);

`ifdef STORE_BYTE_MASK_EN
        sub_store("sb3",  3'b000, 32'h103, 32'h000000AB, 32'hABABABAB, 4'b1000);
        sub_store("sh2",  3'b001, 32'h302, 32'h0000BEEF, 32'hBEEFBEEF, 4'b1100);
        sub_store("sb0",  3'b000, 32'h100, 32'h0000FF55, 32'h55555555, 4'b0001);
        sub_store("sh0",  3'b001, 32'h300, 32'h0000CAFE, 32'hCAFECAFE, 4'b0011);
`else
        sub_store("sb3",  3'b000, 32'h103, 32'h000000AB, 32'h11223344, 32'hAB223344);
        sub_store("sh2",  3'b001, 32'h302, 32'h1234BEEF, 32'h11223344, 32'hBEEF3344);
        sub_store("sb0",  3'b000, 32'h100, 32'h0000FF55, 32'hAABBCCDD, 32'hAABBCC55);
        sub_store("sh0",  3'b001, 32'h300, 32'h0000CAFE, 32'hAABBCCDD, 32'hAABBCAFE);
`endif

        mis_store("mis_sh", 3'b001, 32'h201);
        mis_store("mis_sw", 3'b010, 32'h202);
        mis_store("mis_f3", 3'b011, 32'h100);
        mis_store("mis_s1", 3'b010, 32'h101);

        rst = 1'b1;
        tick();
        check_eq("rst2_mis", 32'(bus.misaligned), 32'd0);
        rst = 1'b0;
        tick();

`ifndef STORE_BYTE_MASK_EN
        // Reset during MERGE must discard the store.
        w0 = we_cnt;
        rd_word = 32'h11223344;
        issue(3'b000, 32'h103, 32'h000000AB);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_addr", bus.mem_addr, 32'h0);
        tick();
        tick();
        check_eq("abort_nwe",  we_cnt - w0, 32'd0);
`endif
        sw_store(32'h100, 32'hDEADBEEF);

        // start held through N, N+1 and the DONE cycle: one write only.
        w0 = we_cnt;
        bus.start    = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h40;
        bus.wdata_in = 32'h00000001;
        tick();
        bus.addr     = 32'h80;
        bus.wdata_in = 32'h00000002;
        check_eq("dbl_addr",  bus.mem_addr, 32'h40);
        check_eq("dbl_wdata", bus.mem_wdata, 32'h1);
        tick();
        check_eq("dbl_done",  32'(bus.done), 32'd1);
        tick();
        bus.start = 1'b0;
        check_eq("dbl_idle",  32'(bus.busy), 32'd0);
        tick();
        check_eq("dbl_nwe",   we_cnt - w0, 32'd1);
        check_eq("overlap",   overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
